two_power_mod: RTL
==================

TWO_POWER_MOD -- requirements
Module: two_power_mod

Interface
REQ-001 SHALL have parameter MOD_WIDTH, default 256, width of modulus and result.
REQ-002 SHALL have parameter INT_WIDTH, default 32, width of exponent field.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_valid  input  1  request valid.
REQ-006 SHALL have port i_ready  output  1  request accepted when i_valid && i_ready at a rising edge.
REQ-007 SHALL have port i_in  input  INT_WIDTH+MOD_WIDTH  packed {power[INT_WIDTH-1:0], modulus[MOD_WIDTH-1:0]}, with power in the MSBs.
REQ-008 SHALL have port o_valid  output  1  result valid.
REQ-009 SHALL have port o_ready  input  1  result consumed when o_valid && o_ready at a rising edge.
REQ-010 SHALL have port o_out  output  MOD_WIDTH  result, 2^power mod modulus.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE; i_ready = (state==IDLE) and o_valid = (state==DONE), both driven combinationally from state.
REQ-012 SHALL, on acceptance, latch modulus, load counter=power, and load r=1 if modulus>=2, else r=0.
REQ-013 SHALL, on acceptance, go to CALC if power!=0 and modulus>=2; otherwise go to DONE.
REQ-014 SHALL, each CALC cycle, compute t=2*r in MOD_WIDTH+1 bits, set r = (t>=modulus) ? t-modulus : t, and decrement counter.
REQ-015 SHALL keep r<modulus at all times during CALC; no truncation is permitted, including for modulus=2^MOD_WIDTH-1.
REQ-016 SHALL go from CALC to DONE on the edge where counter transitions to 0.
REQ-017 SHALL set latency, from the accepting edge to the first edge with o_valid high, to max(power,1) rising edges.
REQ-018 SHALL, in DONE, hold o_out=r stable while o_ready is low, for an unbounded time.
REQ-019 SHALL, in DONE with o_ready high, return to IDLE at that edge; a new request is not accepted in the same cycle.
REQ-020 SHALL drive o_out=r in all states; o_out is only meaningful while o_valid is high.
REQ-021 SHALL produce 0 for modulus 0 and modulus 1, with latency 1.
REQ-022 SHALL ignore i_in and i_valid outside IDLE; the latched operands SHALL NOT change until the next acceptance.

Reset
REQ-023 SHALL, on rst_n low, immediately force state=IDLE, r=0, counter=0 and modulus register=0, independent of clk.
REQ-024 SHALL, after reset, output i_ready=1, o_valid=0 and o_out=0.
REQ-025 SHALL discard an in-flight computation on reset mid-CALC or mid-DONE; no o_valid SHALL follow for it.
REQ-026 SHALL accept a request on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when macro TWO_POWER_RADIX4_EN is defined, perform two chained doubling-reduction steps per CALC cycle when counter>=2 (counter-=2), and one step when counter==1.
REQ-028 SHALL, with TWO_POWER_RADIX4_EN defined, have latency max(ceil(power/2),1) and produce results bit-identical to the undefined build.
REQ-029 SHALL, when TWO_POWER_RADIX4_EN is undefined, perform one step per cycle as in REQ-014 and REQ-017.

Verification
REQ-030 SHALL cover: modulus=13, power=5 -> o_out=6; o_valid 5 edges after acceptance (3 edges with RADIX4).
REQ-031 SHALL cover: modulus=13, power=0 -> o_out=1, latency 1; modulus=1, power=7 -> o_out=0, latency 1; modulus=0 -> o_out=0.
REQ-032 SHALL cover: modulus=256'hE07122F2A4A9E81141ADE518A2CD7574DCB67060B005E24665EF532E0CCA73E1, power=512 -> o_out equals a software model of 2^512 mod N; latency 512 (256 with RADIX4).
REQ-033 SHALL cover: modulus=2^256-1, power=300 -> o_out=2^44, with no overflow.
REQ-034 SHALL cover: o_ready low for 3 cycles in DONE -> o_valid and o_out stable; i_ready stays 0; i_valid pulses during that time are ignored.
REQ-035 SHALL cover: rst_n pulsed low mid-CALC (modulus=13, power=100, after 40 cycles) -> i_ready=1 and o_valid=0 immediately; a following request with modulus=13, power=5 -> o_out=6.

Source files
------------

// File: rtl/two_power_mod.sv
// two_power_mod -- computes 2^power mod modulus by repeated modular doubling.
//
// A request is accepted in IDLE; the operands are latched and the running
// residue r starts at 1 (or 0 when modulus < 2). Each CALC cycle doubles r
// and subtracts the modulus once if needed. This keeps r < modulus throughout,
// so the (MOD_WIDTH+1)-bit intermediate never overflows. The result is held
// in DONE until it is consumed.
//
// Optional build macro:
//   TWO_POWER_RADIX4_EN  - two chained doubling steps per CALC cycle, which
//                          roughly halves latency; results are unchanged.
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_valid  in   request valid
//   i_ready  out  high in IDLE; request accepted on i_valid && i_ready
//   i_in     in   {power[INT_WIDTH-1:0], modulus[MOD_WIDTH-1:0]}
//   o_valid  out  high in DONE
//   o_ready  in   result consumed on o_valid && o_ready
//   o_out    out  residue r (meaningful while o_valid)
module two_power_mod #(
  parameter int MOD_WIDTH = 256,
  parameter int INT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  output logic                           i_ready,
  input  logic [INT_WIDTH+MOD_WIDTH-1:0] i_in,
  output logic                           o_valid,
  input  logic                           o_ready,
  output logic [MOD_WIDTH-1:0]           o_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [MOD_WIDTH-1:0]   r;
  logic [MOD_WIDTH-1:0]   modulus;
  logic [INT_WIDTH-1:0]   counter;

  logic [INT_WIDTH-1:0]   power_in;
  logic [MOD_WIDTH-1:0]   mod_in;
  logic                   mod_in_ge2;
  logic [MOD_WIDTH-1:0]   r_one;
  logic [MOD_WIDTH-1:0]   r_next;
  logic [INT_WIDTH-1:0]   cnt_next;

  // One doubling-reduction step. Because a < m, 2a < 2m, so a single
  // conditional subtraction lands back in [0, m).
  function automatic logic [MOD_WIDTH-1:0] dbl_mod(
    input logic [MOD_WIDTH-1:0] a,
    input logic [MOD_WIDTH-1:0] m
  );
    logic [MOD_WIDTH:0] t;
    t = {a, 1'b0};
    if (t >= {1'b0, m})
      t = t - {1'b0, m};
    return t[MOD_WIDTH-1:0];
  endfunction

  assign power_in   = i_in[INT_WIDTH+MOD_WIDTH-1:MOD_WIDTH];
  assign mod_in     = i_in[MOD_WIDTH-1:0];
  assign mod_in_ge2 = |mod_in[MOD_WIDTH-1:1];

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_out   = r;

  assign r_one = dbl_mod(r, modulus);

`ifdef TWO_POWER_RADIX4_EN
  logic [MOD_WIDTH-1:0] r_two;
  logic                 two_steps;

  assign r_two     = dbl_mod(r_one, modulus);
  assign two_steps = (counter >= INT_WIDTH'(2));

  always_comb begin
    r_next   = r_one;
    cnt_next = counter - INT_WIDTH'(1);
    if (two_steps) begin
      r_next   = r_two;
      cnt_next = counter - INT_WIDTH'(2);
    end
  end
`else
  always_comb begin
    r_next   = r_one;
    cnt_next = counter - INT_WIDTH'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r       <= '0;
      counter <= '0;
      modulus <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            modulus <= mod_in;
            counter <= power_in;
            r       <= mod_in_ge2 ? MOD_WIDTH'(1) : '0;
            // 2^0 = 1 and anything mod 0/1 is 0: no iterations needed
            state   <= (power_in != '0 && mod_in_ge2) ? CALC : DONE;
          end
        end
        CALC: begin
          r       <= r_next;
          counter <= cnt_next;
          if (cnt_next == '0)
            state <= DONE;
        end
        DONE: begin
          if (o_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
